// File: rtl/sfp_mgr_pkg.sv
// Shared encodings for the SFP transmit manager: state codes, field widths, helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package sfp_mgr_pkg;

    localparam int RETRY_W = 4;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_ABSENT      = 3'd0;
    localparam logic [STATE_W-1:0] ST_SETTLE      = 3'd1;
    localparam logic [STATE_W-1:0] ST_DISABLED    = 3'd2;
    localparam logic [STATE_W-1:0] ST_INIT        = 3'd3;
    localparam logic [STATE_W-1:0] ST_RUN         = 3'd4;
    localparam logic [STATE_W-1:0] ST_FAULT_RESET = 3'd5;
    localparam logic [STATE_W-1:0] ST_LOCKOUT     = 3'd6;

    function automatic int cmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sfp_sync_debounce.sv
// Synchronises one asynchronous cage pin and debounces it.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES clk from a stable pin level to a change on dout.
// Backpressure: none; free-running every clk.
// Ports: clk, rst (async, active high), din (raw pin), dout (debounced, registered).
module sfp_sync_debounce #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 1024,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;

    // The counter tracks how long the synchronised level has disagreed with
    // dout; any agreement restarts it, so only an unbroken run commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= {SYNC_STAGES{RESET_VAL}};
            cnt  <= '0;
            dout <= RESET_VAL;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            if (sync[SYNC_STAGES-1] == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                dout <= sync[SYNC_STAGES-1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfp_tx_manager.sv
// Controls TX_DISABLE of one SFP cage from debounced presence/LOS/fault and a software enable.
// Latency: pins reach the FSM SYNC_STAGES+DEBOUNCE_CYCLES clk after settling; outputs are registered.
// Backpressure: none; the FSM steps every clk.
// Ports: clk, rst, mod0_i/rx_loss_i/tx_fault_i (cage pins), enable_i, clear_i ->
//        tx_dis, present_o, rx_loss_o, link_up_o, fault_latched_o, retry_cnt_o, state_o.
module sfp_tx_manager
    import sfp_mgr_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int DEBOUNCE_CYCLES    = 1024,
    parameter int INSERT_WAIT_CYCLES = 2**20,
    parameter int FAULT_INIT_CYCLES  = 2**24,
    parameter int FAULT_RESET_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mod0_i,
    input  logic               rx_loss_i,
    input  logic               tx_fault_i,
    input  logic               enable_i,
    input  logic               clear_i,
    output logic               tx_dis,
    output logic               present_o,
    output logic               rx_loss_o,
    output logic               link_up_o,
    output logic               fault_latched_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [STATE_W-1:0] state_o
);

    localparam int MAX_CYC = cmax(cmax(INSERT_WAIT_CYCLES, FAULT_INIT_CYCLES),
                                  cmax(FAULT_RESET_CYCLES, DEBOUNCE_CYCLES));
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]      T_INSERT = TW'(INSERT_WAIT_CYCLES - 1);
    localparam logic [TW-1:0]      T_INIT   = TW'(FAULT_INIT_CYCLES - 1);
    localparam logic [TW-1:0]      T_FRST   = TW'(FAULT_RESET_CYCLES - 1);
    localparam logic [RETRY_W-1:0] R_MAX    = RETRY_W'(MAX_RETRIES);

    logic present;
    logic los;
    logic fault;

    // MOD_ABS is inverted before debouncing so the debounced flop is present_o
    // itself; its reset value 0 corresponds to "module absent".
    sfp_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0))
        u_present (.clk(clk), .rst(rst), .din(~mod0_i), .dout(present));
    sfp_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1))
        u_los (.clk(clk), .rst(rst), .din(rx_loss_i), .dout(los));
    sfp_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0))
        u_fault (.clk(clk), .rst(rst), .din(tx_fault_i), .dout(fault));

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] nxt;
    logic [RETRY_W-1:0] retry;
    logic [RETRY_W-1:0] retry_nxt;
    logic [TW-1:0]      timer;

    always_comb begin
        nxt       = state;
        retry_nxt = clear_i ? '0 : retry;
        if (!present) begin
            // Removal overrides everything, including a coincident clear.
            nxt       = ST_ABSENT;
            retry_nxt = '0;
        end else begin
            case (state)
                ST_ABSENT:   nxt = ST_SETTLE;
                ST_SETTLE:   if (timer == T_INSERT) nxt = enable_i ? ST_INIT : ST_DISABLED;
                ST_DISABLED: if (enable_i) nxt = ST_INIT;
                ST_INIT, ST_RUN: begin
                    if (!enable_i) begin
                        nxt       = ST_DISABLED;
                        retry_nxt = '0;
                    end else if (fault && (state == ST_RUN || timer == T_INIT)) begin
                        // Recovery: the retry count only climbs while below the
                        // limit, so it saturates instead of wrapping.
                        if (retry_nxt < R_MAX) begin
                            nxt       = ST_FAULT_RESET;
                            retry_nxt = retry_nxt + 1'b1;
                        end else begin
                            nxt = ST_LOCKOUT;
                        end
                    end else if (state == ST_INIT && timer == T_INIT) begin
                        nxt = ST_RUN;
                    end
                end
                ST_FAULT_RESET: begin
                    if (!enable_i) begin
                        nxt       = ST_DISABLED;
                        retry_nxt = '0;
                    end else if (timer == T_FRST) begin
                        nxt = ST_INIT;
                    end
                end
                ST_LOCKOUT:  if (clear_i) nxt = ST_DISABLED;
                default:     nxt = ST_ABSENT;
            endcase
        end
    end

    // Outputs decode the next state so tx_dis changes on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_ABSENT;
            retry           <= '0;
            timer           <= '0;
            tx_dis          <= 1'b1;
            link_up_o       <= 1'b0;
            fault_latched_o <= 1'b0;
        end else begin
            state           <= nxt;
            retry           <= retry_nxt;
            timer           <= (nxt != state) ? '0 : timer + 1'b1;
            tx_dis          <= !(nxt == ST_INIT || nxt == ST_RUN);
            link_up_o       <= (nxt == ST_RUN) && !los;
            fault_latched_o <= (nxt == ST_LOCKOUT);
        end
    end

    assign present_o   = present;
    assign rx_loss_o   = los;
    assign retry_cnt_o = retry;
    assign state_o     = state;

endmodule

// File: tb/tb_sfp_tx_manager.sv
// Bench for sfp_tx_manager: scoreboard of expected state transitions plus direct output checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_sfp_tx_manager;
    import sfp_mgr_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int INSW = 16;
    localparam int FINI = 32;
    localparam int FRST = 8;
    localparam int MAXR = 2;

    logic clk = 1'b0;
    logic rst, mod0_i, rx_loss_i, tx_fault_i, enable_i, clear_i;
    logic tx_dis, present_o, rx_loss_o, link_up_o, fault_latched_o;
    logic [RETRY_W-1:0] retry_cnt_o;
    logic [STATE_W-1:0] state_o;

    sfp_tx_manager #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .INSERT_WAIT_CYCLES(INSW),
        .FAULT_INIT_CYCLES(FINI), .FAULT_RESET_CYCLES(FRST), .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .mod0_i(mod0_i), .rx_loss_i(rx_loss_i), .tx_fault_i(tx_fault_i),
        .enable_i(enable_i), .clear_i(clear_i), .tx_dis(tx_dis), .present_o(present_o),
        .rx_loss_o(rx_loss_o), .link_up_o(link_up_o), .fault_latched_o(fault_latched_o),
        .retry_cnt_o(retry_cnt_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [STATE_W-1:0] st;
        logic [RETRY_W-1:0] retry;
        logic               txd;
        int                 dt;    // clk since previous transition; 0 = not timed
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic push(input logic [STATE_W-1:0] s, input int r, input logic t, input int dt);
        exp_t e;
        e.st    = s;
        e.retry = RETRY_W'(r);
        e.txd   = t;
        e.dt    = dt;
        sbq.push_back(e);
    endtask

    task automatic wait_state(input logic [STATE_W-1:0] s, input int budget, output int n);
        n = 0;
        while (state_o !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", 32'(state_o), 32'(s));
    endtask

    task automatic check_reset();
        chk("rst_txdis", 32'(tx_dis), 1);
        chk("rst_present", 32'(present_o), 0);
        chk("rst_rxloss", 32'(rx_loss_o), 1);
        chk("rst_linkup", 32'(link_up_o), 0);
        chk("rst_latched", 32'(fault_latched_o), 0);
        chk("rst_retry", 32'(retry_cnt_o), 0);
        chk("rst_state", 32'(state_o), 32'(ST_ABSENT));
    endtask

    // Monitor: every observed state change must match the head of the scoreboard.
    initial begin
        logic [STATE_W-1:0] last;
        int   cyc;
        int   last_cyc;
        exp_t e;
        last     = ST_ABSENT;
        cyc      = 0;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (state_o !== last) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'(state_o), 32'(last));
                end else begin
                    e = sbq.pop_front();
                    chk("sb_state", 32'(state_o), 32'(e.st));
                    chk("sb_retry", 32'(retry_cnt_o), 32'(e.retry));
                    chk("sb_txdis", 32'(tx_dis), 32'(e.txd));
                    if (e.dt != 0) chk("sb_dt", 32'(cyc - last_cyc), 32'(e.dt));
                end
                last     = state_o;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; mod0_i = 1'b0; rx_loss_i = 1'b0; tx_fault_i = 1'b0;
        enable_i = 1'b1; clear_i = 1'b0;
        #12;
        check_reset();

        // 1: insertion, settle, init, run
        push(ST_SETTLE, 0, 1'b1, 0);
        push(ST_INIT,   0, 1'b0, INSW);
        push(ST_RUN,    0, 1'b0, FINI);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!present_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("present_lat", 32'(n), SYNC + DEB);
        // one clk in ABSENT to notice presence, then INSERT_WAIT in SETTLE
        wait_state(ST_INIT, 40, n);
        chk("txdis_fall", 32'(n), 1 + INSW);
        wait_state(ST_RUN, 60, n);
        chk("linkup_run", 32'(link_up_o), 1);

        // 2: short fault glitch ignored, longer pulse triggers one recovery
        tx_fault_i = 1'b1;
        repeat (3) @(negedge clk);
        tx_fault_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_run", 32'(state_o), 32'(ST_RUN));
        push(ST_FAULT_RESET, 1, 1'b1, 0);
        push(ST_INIT,        1, 1'b0, FRST);
        push(ST_RUN,         1, 1'b0, FINI);
        tx_fault_i = 1'b1;
        repeat (6) @(negedge clk);
        tx_fault_i = 1'b0;
        wait_state(ST_FAULT_RESET, 20, n);
        wait_state(ST_INIT, 20, n);
        chk("frst_len", 32'(n), FRST);
        wait_state(ST_RUN, 60, n);

        // 3: persistent fault exhausts retries and locks out; clear recovers
        push(ST_FAULT_RESET, 2, 1'b1, 0);
        push(ST_INIT,        2, 1'b0, FRST);
        push(ST_LOCKOUT,     2, 1'b1, FINI);
        tx_fault_i = 1'b1;
        wait_state(ST_LOCKOUT, 120, n);
        chk("lock_latched", 32'(fault_latched_o), 1);
        tx_fault_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("lock_hold", 32'(state_o), 32'(ST_LOCKOUT));
        chk("lock_txdis", 32'(tx_dis), 1);
        push(ST_DISABLED, 0, 1'b1, 0);
        push(ST_INIT,     0, 1'b0, 1);
        push(ST_RUN,      0, 1'b0, FINI);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        wait_state(ST_RUN, 60, n);
        chk("clear_latched", 32'(fault_latched_o), 0);

        // 4: module removal during RUN and INIT
        push(ST_ABSENT, 0, 1'b1, 0);
        mod0_i = 1'b1;
        wait_state(ST_ABSENT, 20, n);
        chk("abs_lat_run", 32'(n <= SYNC + DEB + 1), 1);
        chk("abs_linkup", 32'(link_up_o), 0);
        push(ST_SETTLE, 0, 1'b1, 0);
        push(ST_INIT,   0, 1'b0, INSW);
        mod0_i = 1'b0;
        wait_state(ST_INIT, 40, n);
        repeat (5) @(negedge clk);
        push(ST_ABSENT, 0, 1'b1, 0);
        mod0_i = 1'b1;
        wait_state(ST_ABSENT, 20, n);
        chk("abs_lat_init", 32'(n <= SYNC + DEB + 1), 1);
        push(ST_SETTLE, 0, 1'b1, 0);
        push(ST_INIT,   0, 1'b0, INSW);
        push(ST_RUN,    0, 1'b0, FINI);
        mod0_i = 1'b0;
        wait_state(ST_RUN, 80, n);

        // 5: LOS only affects link_up; dropping enable disables the laser
        chk("los_linkup0", 32'(link_up_o), 1);
        rx_loss_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("los_out", 32'(rx_loss_o), 1);
        chk("los_linkdown", 32'(link_up_o), 0);
        chk("los_txdis", 32'(tx_dis), 0);
        rx_loss_i = 1'b0;
        repeat (10) @(negedge clk);
        chk("los_linkup1", 32'(link_up_o), 1);
        push(ST_DISABLED, 0, 1'b1, 0);
        enable_i = 1'b0;
        wait_state(ST_DISABLED, 5, n);
        chk("dis_linkup", 32'(link_up_o), 0);
        push(ST_INIT, 0, 1'b0, 1);
        push(ST_RUN,  0, 1'b0, FINI);
        enable_i = 1'b1;
        wait_state(ST_RUN, 60, n);

        // 6: asynchronous reset mid-RUN, then mid-FAULT_RESET
        push(ST_ABSENT, 0, 1'b1, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset();
        repeat (2) @(negedge clk);
        tx_fault_i = 1'b1;
        push(ST_SETTLE,      0, 1'b1, 0);
        push(ST_INIT,        0, 1'b0, INSW);
        push(ST_FAULT_RESET, 1, 1'b1, FINI);
        rst = 1'b0;
        wait_state(ST_FAULT_RESET, 80, n);
        repeat (3) @(negedge clk);
        push(ST_ABSENT, 0, 1'b1, 0);
        #2 rst = 1'b1;
        #1 check_reset();
        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
